// File: rtl/spi_byte_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_master_arb
// Description : Mode-0 SPI byte master shared by two requesters. Arbitrates
//               req0/req1, shifts one MSB-first byte out on mosi while
//               capturing miso, and presents the received byte on rx_byte.
//               Optional macro SPI_RR_ARB_EN selects round-robin arbitration;
//               when undefined, requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_master_arb #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] tx0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] tx1,
  output logic       gnt1,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic [1:0] cs_n
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam logic [3:0] PHASE_LAST = 4'(CS_SETUP - 1);
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);

  state_t     state;
  logic [3:0] phase_cnt;   // SETUP / HOLD cycle counter
  logic [7:0] div_cnt;     // clk cycles within the current sclk half-period
  logic [3:0] half_cnt;    // sclk half-periods completed in SHIFT
  logic [6:0] shreg;       // remaining tx bits; bit 7 goes straight to mosi
  logic [7:0] rx_shift;
  logic       id;
  logic       any_req;
  logic       pick;

  assign any_req = req0 | req1;

`ifdef SPI_RR_ARB_EN
  logic last_id;

  // Round robin: a tie goes to the requester not served last
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_id;
  end

  // Track the most recently granted requester; reset value makes the first tie go to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          last_id <= 1'b1;
    else if (state == ST_IDLE && any_req) last_id <= pick;
  end
`else
  // Fixed priority: requester 0 wins any tie
  always_comb pick = ~req0;
`endif

  // Transfer sequencer with registered SPI and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      rx_byte   <= 8'h00;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 2'b11;
      phase_cnt <= 4'd0;
      div_cnt   <= 8'd0;
      half_cnt  <= 4'd0;
      shreg     <= 7'd0;
      rx_shift  <= 8'h00;
      id        <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The done cycle is spent here, so a grant decided now shows up
          // one cycle after done while cs_n is still high.
          if (any_req) begin
            gnt0  <= ~pick;
            gnt1  <= pick;
            id    <= pick;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // tx is taken during the gnt cycle, when the requester has it valid
          busy      <= 1'b1;
          cs_n      <= id ? 2'b01 : 2'b10;
          mosi      <= id ? tx1[7] : tx0[7];
          shreg     <= id ? tx1[6:0] : tx0[6:0];
          rx_shift  <= 8'h00;
          phase_cnt <= 4'd0;
          state     <= ST_SETUP;
        end
        ST_SETUP: begin
          if (phase_cnt == PHASE_LAST) begin
            div_cnt  <= 8'd0;
            half_cnt <= 4'd0;
            state    <= ST_SHIFT;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= 8'd0;
            sclk     <= ~sclk;
            half_cnt <= half_cnt + 4'd1;
            if (!sclk) begin
              rx_shift <= {rx_shift[6:0], miso};
            end else if (half_cnt != 4'd15) begin
              mosi  <= shreg[6];
              shreg <= {shreg[5:0], 1'b0};
            end
            // 16th half-period ends with the 8th falling edge: sclk back low
            if (half_cnt == 4'd15) begin
              phase_cnt <= 4'd0;
              state     <= ST_HOLD;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (phase_cnt == PHASE_LAST) begin
            cs_n    <= 2'b11;
            done    <= 1'b1;
            done_id <= id;
            rx_byte <= rx_shift;
            busy    <= 1'b0;
            mosi    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_byte_master_arb
// Description : Directed bench for spi_byte_master_arb: one default instance
//               with a mode-0 slave model, one CLK_DIV=2/CS_SETUP=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_byte_master_arb;

  logic       clk;
  logic       reset;
  logic       req0, req1;
  logic [7:0] tx0, tx1;
  logic       gnt0, gnt1, busy, done, done_id, sclk, mosi, miso;
  logic [7:0] rx_byte;
  logic [1:0] cs_n;

  logic       req0_b;
  logic [7:0] tx0_b;
  logic       gnt0_b, gnt1_b, busy_b, done_b, done_id_b, sclk_b, mosi_b;
  logic [7:0] rx_byte_b;
  logic [1:0] cs_n_b;
  logic       req1_b;
  logic [7:0] tx1_b;
  logic       miso_b;

  logic [7:0] slave_byte;
  bit   [3:0] falls, rises, rises_b;
  bit         sclk_q, sclk_bq;
  bit   [7:0] mosi_bits, mosi_bits_b;
  int         gnt0_cnt;
  int         cyc;
  int         last_rise_b, gap_b;

  int vectors = 0;
  int errors  = 0;

  spi_byte_master_arb dut (
    .clk(clk), .reset(reset),
    .req0(req0), .tx0(tx0), .gnt0(gnt0),
    .req1(req1), .tx1(tx1), .gnt1(gnt1),
    .busy(busy), .done(done), .done_id(done_id), .rx_byte(rx_byte),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_byte_master_arb #(.CLK_DIV(2), .CS_SETUP(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0_b), .tx0(tx0_b), .gnt0(gnt0_b),
    .req1(req1_b), .tx1(tx1_b), .gnt1(gnt1_b),
    .busy(busy_b), .done(done_b), .done_id(done_id_b), .rx_byte(rx_byte_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: MSB first, next bit presented after each sclk fall
  assign miso = slave_byte[3'd7 - falls[2:0]];

  // Edge monitor for the default instance
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    sclk_q <= sclk;
    if (reset || gnt0 || gnt1) begin
      falls <= 4'd0;
      rises <= 4'd0;
    end else begin
      if (sclk_q && !sclk) falls <= falls + 4'd1;
      if (!sclk_q && sclk) begin
        rises     <= rises + 4'd1;
        mosi_bits <= {mosi_bits[6:0], mosi};
      end
    end
    if (reset)     gnt0_cnt <= 0;
    else if (gnt0) gnt0_cnt <= gnt0_cnt + 1;
  end

  // Edge monitor for the fast instance
  always @(posedge clk) begin
    sclk_bq <= sclk_b;
    if (reset || gnt0_b || gnt1_b) begin
      rises_b <= 4'd0;
    end else if (!sclk_bq && sclk_b) begin
      rises_b     <= rises_b + 4'd1;
      mosi_bits_b <= {mosi_bits_b[6:0], mosi_b};
      gap_b       <= cyc - last_rise_b;
      last_rise_b <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for a grant, then count cycles from gnt to done. Called at a negedge.
  task automatic xfer(input bit keep, output int lat, output logic [1:0] cs_mid,
                      output logic [1:0] cs_gnt, output int wait_n);
    int n;
    lat    = -1;
    cs_mid = 2'bxx;
    cs_gnt = 2'bxx;
    wait_n = 0;
    while (!(gnt0 || gnt1) && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!(gnt0 || gnt1)) return;
    cs_gnt = cs_n;
    if (!keep) begin
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) cs_mid = cs_n;
    end while (!done && n < 200);
    if (done) lat = n;
  endtask

  initial begin
    int         lat, w, n, snap;
    logic [1:0] cm, cg;
    logic       e0, e1, e2;

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; tx0 = 8'h00; tx1 = 8'h00;
    req0_b = 1'b0; req1_b = 1'b0; tx0_b = 8'h00; tx1_b = 8'h00; miso_b = 1'b1;
    slave_byte = 8'h00;

    // Reset values
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 2'b11);
    reset = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of SHIFT
    slave_byte = 8'h5A; tx0 = 8'hFF; req0 = 1'b1;
    n = 0;
    while (rises != 4'd3 && n < 300) begin
      @(negedge clk);
      n++;
      if (gnt0) req0 = 1'b0;
    end
    chk("t1_three_rises", rises, 3);
    chk("t1_mosi_before", mosi, 1);
    reset = 1'b1;
    #1;
    chk("t1_cs_n_async", cs_n, 2'b11);
    chk("t1_sclk_async", sclk, 0);
    chk("t1_mosi_async", mosi, 0);
    chk("t1_busy_async", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t1_no_done", done, 0);
    chk("t1_rx_byte", rx_byte, 8'h00);

    // Requester 0, A5 out, 3C back
    tx0 = 8'hA5; slave_byte = 8'h3C; req0 = 1'b1;
    xfer(1'b0, lat, cm, cg, w);
    chk("t2_latency", lat, 69);
    chk("t2_mosi_bits", mosi_bits, 8'hA5);
    chk("t2_rises", rises, 8);
    chk("t2_cs_n", cm, 2'b10);
    chk("t2_rx_byte", rx_byte, 8'h3C);
    chk("t2_done_id", done_id, 0);

    // Requester 1, FF out, miso low
    snap = gnt0_cnt;
    tx1 = 8'hFF; slave_byte = 8'h00; req1 = 1'b1;
    xfer(1'b0, lat, cm, cg, w);
    chk("t3_latency", lat, 69);
    chk("t3_mosi_bits", mosi_bits, 8'hFF);
    chk("t3_cs_n", cm, 2'b01);
    chk("t3_rx_byte", rx_byte, 8'h00);
    chk("t3_done_id", done_id, 1);
    chk("t3_no_gnt0", gnt0_cnt, snap);

    // Both requesters held for three transfers
`ifdef SPI_RR_ARB_EN
    e0 = 1'b0; e1 = 1'b1; e2 = 1'b0;
`else
    e0 = 1'b0; e1 = 1'b0; e2 = 1'b0;
`endif
    slave_byte = 8'h96; tx0 = 8'h11; tx1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    xfer(1'b1, lat, cm, cg, w);
    chk("t4_id_first", done_id, e0);
    chk("t4_rx_first", rx_byte, 8'h96);
    xfer(1'b1, lat, cm, cg, w);
    chk("t4_id_second", done_id, e1);
    xfer(1'b1, lat, cm, cg, w);
    chk("t4_id_third", done_id, e2);

    // req0 held: back-to-back grants one cycle after done
    req1 = 1'b0;
    xfer(1'b1, lat, cm, cg, w);
    chk("t5_gnt_gap1", w, 1);
    chk("t5_cs_high_at_gnt1", cg, 2'b11);
    chk("t5_id1", done_id, 0);
    xfer(1'b0, lat, cm, cg, w);
    chk("t5_gnt_gap2", w, 1);
    chk("t5_cs_high_at_gnt2", cg, 2'b11);
    chk("t5_latency", lat, 69);
    snap = gnt0_cnt;
    repeat (5) @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    chk("t5_no_regrant", gnt0_cnt, snap);

    // Fast instance: CLK_DIV=2, CS_SETUP=1
    tx0_b = 8'h81; req0_b = 1'b1;
    n = 0;
    while (!gnt0_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    req0_b = 1'b0;
    cm = 2'bxx;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) cm = cs_n_b;
    end while (!done_b && n < 100);
    lat = done_b ? n : -1;
    chk("t6_latency", lat, 35);
    chk("t6_rises", rises_b, 8);
    chk("t6_sclk_period", gap_b, 4);
    chk("t6_mosi_bits", mosi_bits_b, 8'h81);
    chk("t6_cs_n", cm, 2'b10);
    chk("t6_rx_byte", rx_byte_b, 8'hFF);
    chk("t6_done_id", done_id_b, 0);
    chk("t6_busy_at_done", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
